// File: rtl/trn_tlp_pkg.sv
// Shared TRN/TLP constants, FSM state encoding and the MRd descriptor record.
package trn_tlp_pkg;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
  localparam logic [4:0] TYPE_MRD       = 5'b0_0000;

  localparam logic [7:0] TREM_QW    = 8'h00;
  localparam logic [7:0] TREM_DW_HI = 8'h0F;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TURN = 2'd1,
    HDR0      = 2'd2,
    HDR1      = 2'd3
  } mrd_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [9:0]  len_dw;
    logic [7:0]  tag;
  } mrd_desc_t;

endpackage

// File: rtl/tlp_mrd_hdr_builder.sv
// Combinational MRd header formatter: descriptor + requester ID -> two TRN qwords.
module tlp_mrd_hdr_builder
  import trn_tlp_pkg::*;
(
  input  mrd_desc_t   desc,
  input  logic [15:0] completer_id,
  output logic [63:0] qw0,
  output logic [63:0] qw1,
  output logic        is4dw
);

  logic [1:0]  fmt;
  logic [3:0]  last_be;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] addr_lo;

  // Build both header qwords; a single-DW read must carry lastBE = 0.
  always_comb begin
    is4dw   = |desc.addr[63:32];
    fmt     = is4dw ? FMT_4DW_NODATA : FMT_3DW_NODATA;
    last_be = (desc.len_dw == 10'd1) ? 4'h0 : 4'hF;
    addr_lo = desc.addr[31:0] & ~32'h3;
    dw0     = {1'b0, fmt, TYPE_MRD, 14'b0, desc.len_dw};
    dw1     = {completer_id, desc.tag, last_be, 4'hF};
    qw0     = {dw0, dw1};
    qw1     = is4dw ? {desc.addr[63:32], addr_lo} : {addr_lo, 32'h0};
  end

endmodule

// File: rtl/tx_turn_mrd_requester.sv
// Turn-arbitrated MRd requester: holds one descriptor, waits for a tx_turn grant
// with non-posted credit, then drives one MRd TLP on the TRN Tx interface.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | descriptor slot empty, req_ready high
//  WAIT_TURN | descriptor held, waiting for tx_turn with buffer credit
//  HDR0      | driving qword 0 (SOF), waiting for tdst_rdy
//  HDR1      | driving qword 1 (EOF), waiting for tdst_rdy
module tx_turn_mrd_requester
  import trn_tlp_pkg::*;
#(
  parameter int BUF_AV_BIT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_addr,
  input  logic [9:0]       req_len_dw,
  input  logic [7:0]       req_tag,
  input  logic [15:0]      cfg_completer_id,
  input  logic             tx_turn,
  output logic             tx_driven,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  output logic             trn_tsrc_dsc_n,
  input  logic             trn_tdst_rdy_n,
  input  logic             trn_tdst_dsc_n,
  input  logic [3:0]       trn_tbuf_av,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] discard_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mrd_state_e       state, state_nxt;
  mrd_desc_t        desc, desc_nxt;
  logic             driven_nxt, src_rdy_n_nxt, sof_n_nxt, eof_n_nxt;
  logic [63:0]      td_nxt;
  logic [7:0]       trem_n_nxt;
  logic [CNT_W-1:0] issued_nxt, discard_nxt;
  logic [63:0]      qw0, qw1;
  logic             is4dw;
  logic             buf_ok;

  tlp_mrd_hdr_builder u_hdr (
    .desc         (desc),
    .completer_id (cfg_completer_id),
    .qw0          (qw0),
    .qw1          (qw1),
    .is4dw        (is4dw)
  );

  assign buf_ok         = |(trn_tbuf_av & (4'b0001 << BUF_AV_BIT));
  assign req_ready      = (state == IDLE);
  assign trn_tsrc_dsc_n = 1'b1;

  // Next-state and next registered-output decode; everything holds by default,
  // which also keeps td/trem/sof/eof stable across destination stalls.
  always_comb begin
    state_nxt     = state;
    desc_nxt      = desc;
    driven_nxt    = tx_driven;
    src_rdy_n_nxt = trn_tsrc_rdy_n;
    sof_n_nxt     = trn_tsof_n;
    eof_n_nxt     = trn_teof_n;
    td_nxt        = trn_td;
    trem_n_nxt    = trn_trem_n;
    issued_nxt    = issued_cnt;
    discard_nxt   = discard_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          desc_nxt.addr   = req_addr;
          desc_nxt.len_dw = req_len_dw;
          desc_nxt.tag    = req_tag;
          state_nxt       = WAIT_TURN;
        end
      end
      WAIT_TURN: begin
        if (tx_turn && buf_ok) begin
          state_nxt     = HDR0;
          driven_nxt    = 1'b1;
          src_rdy_n_nxt = 1'b0;
          sof_n_nxt     = 1'b0;
          eof_n_nxt     = 1'b1;
          td_nxt        = qw0;
          trem_n_nxt    = TREM_QW;
        end
      end
      HDR0, HDR1: begin
        if (!trn_tdst_dsc_n) begin
          // Aborted frame: keep the descriptor so the next turn resends it.
          state_nxt     = WAIT_TURN;
          driven_nxt    = 1'b0;
          src_rdy_n_nxt = 1'b1;
          sof_n_nxt     = 1'b1;
          eof_n_nxt     = 1'b1;
          discard_nxt   = discard_cnt + CNT_ONE;
        end else if (!trn_tdst_rdy_n) begin
          if (state == HDR0) begin
            state_nxt  = HDR1;
            sof_n_nxt  = 1'b1;
            eof_n_nxt  = 1'b0;
            td_nxt     = qw1;
            trem_n_nxt = is4dw ? TREM_QW : TREM_DW_HI;
          end else begin
            state_nxt     = IDLE;
            driven_nxt    = 1'b0;
            src_rdy_n_nxt = 1'b1;
            eof_n_nxt     = 1'b1;
            issued_nxt    = issued_cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, descriptor and registered TRN outputs.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state          <= IDLE;
      desc           <= '0;
      tx_driven      <= 1'b0;
      trn_tsrc_rdy_n <= 1'b1;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_td         <= '0;
      trn_trem_n     <= TREM_QW;
      issued_cnt     <= '0;
      discard_cnt    <= '0;
    end else begin
      state          <= state_nxt;
      desc           <= desc_nxt;
      tx_driven      <= driven_nxt;
      trn_tsrc_rdy_n <= src_rdy_n_nxt;
      trn_tsof_n     <= sof_n_nxt;
      trn_teof_n     <= eof_n_nxt;
      trn_td         <= td_nxt;
      trn_trem_n     <= trem_n_nxt;
      issued_cnt     <= issued_nxt;
      discard_cnt    <= discard_nxt;
    end
  end

endmodule

// File: tb/tb_tx_turn_mrd_requester.sv
// Randomised bench for tx_turn_mrd_requester with an arithmetic header model
// and plain integer counters as the reference.
module tb_tx_turn_mrd_requester;

  logic        trn_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [9:0]  req_len_dw = '0;
  logic [7:0]  req_tag = '0;
  logic [15:0] cfg_completer_id = '0;
  logic        tx_turn = 1'b0;
  logic        tx_driven;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n = 1'b1;
  logic        trn_tdst_dsc_n = 1'b1;
  logic [3:0]  trn_tbuf_av = 4'hF;
  logic [15:0] issued_cnt, discard_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_iss    = 0;
  int n_dsc    = 0;

  tx_turn_mrd_requester #(.BUF_AV_BIT(1), .CNT_W(16)) dut (
    .trn_clk          (trn_clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len_dw       (req_len_dw),
    .req_tag          (req_tag),
    .cfg_completer_id (cfg_completer_id),
    .tx_turn          (tx_turn),
    .tx_driven        (tx_driven),
    .trn_td           (trn_td),
    .trn_trem_n       (trn_trem_n),
    .trn_tsof_n       (trn_tsof_n),
    .trn_teof_n       (trn_teof_n),
    .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n   (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n   (trn_tdst_rdy_n),
    .trn_tdst_dsc_n   (trn_tdst_dsc_n),
    .trn_tbuf_av      (trn_tbuf_av),
    .issued_cnt       (issued_cnt),
    .discard_cnt      (discard_cnt)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge trn_clk);
  endtask

  function automatic logic [63:0] model_qw0(input logic [63:0] addr, input logic [9:0] len,
                                            input logic [7:0] tag, input logic [15:0] id);
    logic [31:0] dw0, dw1;
    dw0 = ((addr >> 32) != 0 ? 32'h2000_0000 : 32'h0) + 32'(len);
    dw1 = 32'(id) * 32'd65536 + 32'(tag) * 32'd256 + ((len == 10'd1) ? 32'd15 : 32'd255);
    return {dw0, dw1};
  endfunction

  function automatic logic [63:0] model_qw1(input logic [63:0] addr);
    logic [31:0] lo, hi;
    lo = 32'(addr % 64'h1_0000_0000);
    lo = lo - (lo % 32'd4);
    hi = 32'(addr >> 32);
    return (hi != 0) ? {hi, lo} : {lo, 32'h0};
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, "_driven"}, 64'(tx_driven), 64'd0);
    check_val({tag, "_src_rdy_n"}, 64'(trn_tsrc_rdy_n), 64'd1);
    check_val({tag, "_sof_n"}, 64'(trn_tsof_n), 64'd1);
    check_val({tag, "_eof_n"}, 64'(trn_teof_n), 64'd1);
    check_val({tag, "_td"}, trn_td, 64'd0);
    check_val({tag, "_trem_n"}, 64'(trn_trem_n), 64'd0);
    check_val({tag, "_issued"}, 64'(issued_cnt), 64'd0);
    check_val({tag, "_discard"}, 64'(discard_cnt), 64'd0);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check_val({tag, "_src_dsc_n"}, 64'(trn_tsrc_dsc_n), 64'd1);
  endtask

  // One full request: latch, optional ignored turns, grant, two qwords with
  // stalls, optional discard (then resend), final accept.
  task automatic do_txn(input logic [63:0] addr, input logic [9:0] len, input logic [7:0] tag,
                        input logic [15:0] id, input int pre, input bit bogus,
                        input int st0, input int st1, input int dsc_at);
    logic [63:0] e0, e1;
    logic [7:0]  etrem;
    bit          done;
    int          d;
    e0    = model_qw0(addr, len, tag, id);
    e1    = model_qw1(addr);
    etrem = ((addr >> 32) != 0) ? 8'h00 : 8'h0F;
    check_val("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_len_dw = len; req_tag = tag;
    cfg_completer_id = id;
    step();
    req_valid = 1'b0; req_addr = 64'(($urandom)); req_len_dw = 10'($urandom); req_tag = 8'($urandom);
    check_val("ready_busy", 64'(req_ready), 64'd0);
    done = 1'b0;
    d = dsc_at;
    while (!done) begin
      for (int i = 0; i < pre; i++) begin
        tx_turn = bogus;
        trn_tbuf_av = bogus ? (4'($urandom) & 4'hD) : 4'($urandom);
        step();
        check_val("wait_driven", 64'(tx_driven), 64'd0);
        check_val("wait_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
      end
      tx_turn = 1'b1; trn_tbuf_av = 4'($urandom) | 4'h2;
      step();
      tx_turn = 1'b0;
      check_val("sof_driven", 64'(tx_driven), 64'd1);
      check_val("sof_sof_n", 64'(trn_tsof_n), 64'd0);
      check_val("sof_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd0);
      check_val("sof_eof_n", 64'(trn_teof_n), 64'd1);
      check_val("qw0", trn_td, e0);
      check_val("qw0_trem_n", 64'(trn_trem_n), 64'h00);
      for (int i = 0; i < st0; i++) begin
        tx_turn = 1'($urandom);
        step();
        check_val("stall0_td", trn_td, e0);
        check_val("stall0_sof_n", 64'(trn_tsof_n), 64'd0);
        check_val("stall0_driven", 64'(tx_driven), 64'd1);
      end
      tx_turn = 1'b0;
      if (d == 1) begin
        trn_tdst_dsc_n = 1'b0; trn_tdst_rdy_n = 1'b0;
        step();
        trn_tdst_dsc_n = 1'b1; trn_tdst_rdy_n = 1'b1;
        n_dsc++;
        check_val("dsc0_driven", 64'(tx_driven), 64'd0);
        check_val("dsc0_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
        check_val("dsc0_sof_n", 64'(trn_tsof_n), 64'd1);
        check_val("dsc0_discard", 64'(discard_cnt), 64'(16'(n_dsc)));
        d = 0;
      end else begin
        trn_tdst_rdy_n = 1'b0;
        step();
        trn_tdst_rdy_n = 1'b1;
        check_val("qw1", trn_td, e1);
        check_val("qw1_trem_n", 64'(trn_trem_n), 64'(etrem));
        check_val("qw1_eof_n", 64'(trn_teof_n), 64'd0);
        check_val("qw1_sof_n", 64'(trn_tsof_n), 64'd1);
        for (int i = 0; i < st1; i++) begin
          tx_turn = 1'($urandom);
          step();
          check_val("stall1_td", trn_td, e1);
          check_val("stall1_eof_n", 64'(trn_teof_n), 64'd0);
          check_val("stall1_driven", 64'(tx_driven), 64'd1);
        end
        tx_turn = 1'b0;
        if (d == 2) begin
          trn_tdst_dsc_n = 1'b0; trn_tdst_rdy_n = 1'b0;
          step();
          trn_tdst_dsc_n = 1'b1; trn_tdst_rdy_n = 1'b1;
          n_dsc++;
          check_val("dsc1_driven", 64'(tx_driven), 64'd0);
          check_val("dsc1_eof_n", 64'(trn_teof_n), 64'd1);
          check_val("dsc1_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
          check_val("dsc1_discard", 64'(discard_cnt), 64'(16'(n_dsc)));
          check_val("dsc1_ready", 64'(req_ready), 64'd0);
          d = 0;
        end else begin
          trn_tdst_rdy_n = 1'b0;
          step();
          trn_tdst_rdy_n = 1'b1;
          n_iss++;
          check_val("end_driven", 64'(tx_driven), 64'd0);
          check_val("end_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
          check_val("end_eof_n", 64'(trn_teof_n), 64'd1);
          check_val("end_issued", 64'(issued_cnt), 64'(16'(n_iss)));
          check_val("end_ready", 64'(req_ready), 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    check_reset_state("reset");

    // 3DW, turn three clocks after the request.
    do_txn(64'h0000_0000_1234_5678, 10'd16, 8'h05, 16'h0100, 3, 1'b0, 0, 0, 0);
    // 4DW, single DW.
    do_txn(64'h0000_0001_0000_0040, 10'd1, 8'h07, 16'h0100, 0, 1'b0, 0, 0, 0);
    // Four-cycle destination stall in HDR0.
    do_txn(64'h0000_0000_0000_1000, 10'd0, 8'h11, 16'h0203, 1, 1'b0, 4, 0, 0);
    // Turn with nothing queued, then turns without credit.
    tx_turn = 1'b1; trn_tbuf_av = 4'hF;
    step();
    tx_turn = 1'b0;
    check_val("noreq_driven", 64'(tx_driven), 64'd0);
    check_val("noreq_src_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
    do_txn(64'h0000_0000_0000_2004, 10'd8, 8'h22, 16'h0100, 2, 1'b1, 0, 0, 0);
    // Discard in HDR1 then identical resend.
    do_txn(64'h0000_0000_ABCD_0000, 10'd4, 8'h33, 16'h0100, 1, 1'b0, 0, 1, 2);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      logic [9:0]  l;
      a = {($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0, 32'($urandom)};
      l = ($urandom_range(0, 4) == 0) ? 10'd1 : 10'($urandom);
      do_txn(a, l, 8'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end

    // Reset while in HDR1 drops the frame and descriptor.
    req_valid = 1'b1; req_addr = 64'h0000_0000_0000_0100; req_len_dw = 10'd2; req_tag = 8'h44;
    step();
    req_valid = 1'b0; tx_turn = 1'b1; trn_tbuf_av = 4'hF;
    step();
    tx_turn = 1'b0; trn_tdst_rdy_n = 1'b0;
    step();
    trn_tdst_rdy_n = 1'b1;
    check_val("pre_reset_eof_n", 64'(trn_teof_n), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_iss = 0; n_dsc = 0;
    check_reset_state("midreset");
    do_txn(64'h0000_0000_0000_0200, 10'd3, 8'h55, 16'h0100, 0, 1'b0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
